// File: rtl/fifo_rptr_empty_if.sv
// Read-side bus of the asynchronous FIFO: write-pointer input, memory read
// port and the output handshake toward the consumer.
interface fifo_rptr_empty_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);

  logic [ADDR_WIDTH:0]   wptr_gray;
  logic [DATA_WIDTH-1:0] rdata_mem;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH:0]   rptr_gray;
  logic                  rempty;
  logic [ADDR_WIDTH:0]   rcount;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;

  // The read-control block itself.
  modport master (
    input  wptr_gray,
    input  rdata_mem,
    input  dout_ready,
    output raddr,
    output rptr_gray,
    output rempty,
    output rcount,
    output dout,
    output dout_valid
  );

  // The surroundings: write domain, memory and consumer.
  modport slave (
    output wptr_gray,
    output rdata_mem,
    output dout_ready,
    input  raddr,
    input  rptr_gray,
    input  rempty,
    input  rcount,
    input  dout,
    input  dout_valid
  );

endinterface

// File: rtl/fifo_rptr_empty.sv
// Read-side control of the asynchronous FIFO. Brings the Gray write pointer
// into the read clock domain, keeps the binary/Gray read pointer, produces the
// empty flag and an occupancy count, and presents memory words to the consumer
// through a one-entry output register with a valid/ready handshake.
module fifo_rptr_empty #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input logic               rclk,
  input logic               rrst,
  fifo_rptr_empty_if.master bus
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wq1;
  logic [PW-1:0]         wq2;
  logic [PW-1:0]         rbin;
  logic [PW-1:0]         rbin_next;
  logic [PW-1:0]         rgray_next;
  logic [PW-1:0]         rgray_q;
  logic [PW-1:0]         wbin_sync;
  logic [PW-1:0]         rcount_q;
  logic                  rempty_q;
  logic                  pop;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;

  // Each binary bit is the XOR of all Gray bits at and above its position.
  function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int i = 0; i < PW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // Two-flop synchronizer for the write pointer; only wq2 is trusted.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= bus.wptr_gray;
      wq2 <= wq1;
    end
  end

  // Pop whenever memory holds a word and the output register is free or draining.
  always_comb begin
    pop        = !rempty_q && (!dout_valid_q || bus.dout_ready);
    rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, pop};
    rgray_next = (rbin_next >> 1) ^ rbin_next;
    wbin_sync  = gray_to_bin(wq2);
  end

  // Read pointer, empty flag and count all look ahead to the post-pop pointer.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin     <= '0;
      rgray_q  <= '0;
      rempty_q <= 1'b1;
      rcount_q <= '0;
    end else begin
      rbin     <= rbin_next;
      rgray_q  <= rgray_next;
      rempty_q <= (rgray_next == wq2);
      rcount_q <= wbin_sync - rbin_next;
    end
  end

  // Output register: a pop loads a new word, otherwise an accepted word empties it.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (pop) begin
      dout_q       <= bus.rdata_mem;
      dout_valid_q <= 1'b1;
    end else if (dout_valid_q && bus.dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

  assign bus.raddr      = rbin[ADDR_WIDTH-1:0];
  assign bus.rptr_gray  = rgray_q;
  assign bus.rempty     = rempty_q;
  assign bus.rcount     = rcount_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: doc/fifo_rptr_empty.md
# fifo_rptr_empty

Read-side control stage of the asynchronous FIFO, directly downstream of the 16-entry dual-port FIFO memory. Synchronizes the write-domain Gray write pointer into the read clock domain and keeps the binary/Gray read pointer. Generates the registered empty flag and an occupancy count. Drives the memory read address and captures the memory's combinational read data into a one-entry output register with a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32, word width; must match the memory.
- `ADDR_WIDTH`, 4, memory address width (16 entries); pointers are `ADDR_WIDTH+1` bits.
- `rclk`  in  1  read-domain clock; the only clock.
- `rrst`  in  1  reset, synchronous and active-high.
- `wptr_gray`  in  ADDR_WIDTH+1  Gray write pointer from the write domain; asynchronous to `rclk`, changes at most one bit per update.
- `rdata_mem`  in  DATA_WIDTH  combinational read data from the memory, `MEM[raddr]`.
- `raddr`  out  ADDR_WIDTH  memory read address, equal to `rbin[ADDR_WIDTH-1:0]`.
- `rptr_gray`  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
- `rempty`  out  1  registered empty flag for the memory; it excludes the output register.
- `rcount`  out  ADDR_WIDTH+1  registered count of words in memory not yet popped, range 0..16.
- `dout`  out  DATA_WIDTH  output data.
- `dout_valid`  out  1  `dout` holds a word.
- `dout_ready`  in  1  the consumer accepts `dout` this cycle.

## Operation
- **Synchronizer.** Two-flop chain `wq1 <= wptr_gray`, `wq2 <= wq1`. Only `wq2` is used downstream.
- **Pop condition.** `pop = !rempty && (!dout_valid || dout_ready)`.
- **Pointer update.**
  - `rbin_next = rbin + pop`, modulo 2^(ADDR_WIDTH+1).
  - `rgray_next = (rbin_next >> 1) ^ rbin_next`.
  - On each edge: `rbin <= rbin_next` and `rptr_gray <= rgray_next`.
- **Empty.** `rempty <= (rgray_next == wq2)`.
- **Count.** `rcount <= gray2bin(wq2) - rbin_next`, modulo 2^(ADDR_WIDTH+1).
- **Output register.**
  - On `pop`: `dout <= rdata_mem`, `dout_valid <= 1`.
  - Else if `dout_valid && dout_ready`: `dout_valid <= 0`; `dout` is unchanged.
  - Otherwise `dout` and `dout_valid` hold.
- **Simultaneous events.** When `dout_valid && dout_ready` and a `pop` occur in the same cycle, the new word replaces the old one and `dout_valid` stays 1. This gives full throughput of one word per cycle.
- **Backpressure.** While `dout_valid && !dout_ready`, `dout` is stable and no pop occurs.
- **Wrap-around.**
  - `rbin` wraps 31→0.
  - `raddr` wraps 15→0.
  - Gray sequence across the wrap: bin 30→31→0 gives 10001→10000→00000.
- **Reset values** (applied on the edge where `rrst`=1):
  - `rbin`=0, `rptr_gray`=0, `raddr`=0.
  - `wq1`=0, `wq2`=0.
  - `rempty`=1, `rcount`=0.
  - `dout`=0, `dout_valid`=0.
- **Reset mid-operation.** Any word held in `dout` is dropped on that edge. Resetting the write side at the same time is a system-level requirement; this block does not check pointer consistency.
- **Not produced.** No overflow or underflow flag. A pop never occurs while `rempty`=1.

## Timing
- Sample `wptr_gray` change, stable before edge E0:
  - `wq1` updates at E0.
  - `wq2` updates at E1.
  - `rempty` falls at E2.
  - `pop` is high in the E2–E3 cycle.
  - `dout_valid`=1 and `dout` are valid after E3.
- Latency from a write-pointer change to output: 4 `rclk` edges.
- Each `pop` updates `raddr` and `rptr_gray` at the same edge as `dout`.
- `rempty` is set at the edge of the pop that consumes the last synchronized word. It is therefore never stale-low for a popped word.
- `rempty` and `rcount` are pessimistic by the 2-cycle synchronizer delay. This is allowed.
- All outputs are registered except `raddr`, which is the `rbin` register bits.

## Test plan
- **Reset.** Hold `rrst`=1 for 2 cycles with arbitrary inputs → `rempty`=1, `dout_valid`=0, `raddr`=0, `rptr_gray`=00000, `rcount`=0.
- **Single word.** Set `MEM[0]`=0xA5A50001 and step `wptr_gray` 00000→00001, with `dout_ready`=1 → `dout_valid`=1 after the 4th edge, `dout`=0xA5A50001, `raddr`=1, `rptr_gray`=00001, `rempty`=1.
- **Burst of 16.** Load `MEM[0..15]` with 0x10..0x1F and set `wptr_gray`=11000 (bin 16), with `dout_ready`=1 → 16 consecutive valid beats 0x10..0x1F in order. `rcount` first reads 16 and decrements by one per pop. `rempty`=1 after the 16th pop and `dout_valid`=0 the cycle after.
- **Backpressure.** Three words available, `dout_ready`=0 → exactly one pop; `dout` is held stable and `rcount`=2. Raise `dout_ready` → the remaining 2 words follow on back-to-back cycles.
- **Wrap.** Pre-advance 30 words, then make 4 more available → `raddr` 14,15,0,1 and `rptr_gray` 10001,10000,00000,00001. Data is in order.
- **Reset mid-burst.** Assert `rrst` while `dout_valid`=1 and `rcount`=5 → next edge `dout_valid`=0, `rempty`=1, `rcount`=0, `raddr`=0.
